// File: rtl/datapath_register_file.sv
// datapath_register_file
// General-purpose register file and status-flag register feeding the
// function unit's ABus/BBus operands. One synchronous write port, two
// combinational read ports, one 4-bit {V,C,N,Z} flag register.
// R0 is hardwired to zero: writes to it are dropped, reads return 0.
//
// Optional feature, selected by the REGFILE_BYPASS_EN macro:
//   defined     - write-through forwarding: a pending write (RW=1, DA!=0)
//                 to the address being read appears on that bus before
//                 the clock edge.
//   not defined - no forwarding; buses always show the stored contents.
//
// There is no handshake on any port: every input is sampled on each
// rising CLK edge, and the read buses are purely combinational.

module datapath_register_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [ADDR_W-1:0] AA,
    input  logic [ADDR_W-1:0] BA,
    input  logic [ADDR_W-1:0] DA,
    input  logic              RW,
    input  logic [DATA_W-1:0] DData,
    input  logic              FlagLd,
    input  logic              V,
    input  logic              C,
    input  logic              N,
    input  logic              Z,
    output logic [DATA_W-1:0] ABus,
    output logic [DATA_W-1:0] BBus,
    output logic [3:0]        Status
);

    localparam int NREG = 1 << ADDR_W;

    // Storage for R1..R(NREG-1). R0 has no storage; the read mux
    // returns zero for address 0 by default.
    logic [DATA_W-1:0] regs [1:NREG-1];

    // Stored (un-forwarded) read values for each port.
    logic [DATA_W-1:0] a_raw;
    logic [DATA_W-1:0] b_raw;

    // A write is only meaningful for a nonzero destination.
    logic wr_valid;
    assign wr_valid = RW && (DA != '0);

    // One register per nonzero address; each clears asynchronously and
    // loads DData when it is the selected destination.
    for (genvar i = 1; i < NREG; i++) begin : g_reg
        logic sel;
        assign sel = wr_valid && (DA == ADDR_W'(i));

        // Register i: async clear, synchronous load on its own select.
        always_ff @(posedge CLK or negedge RESET_N) begin
            if (!RESET_N) begin
                regs[i] <= '0;
            end else if (sel) begin
                regs[i] <= DData;
            end
        end
    end

    // Read muxes: scan the array; address 0 matches nothing and falls
    // through to the zero default, which implements the hardwired R0.
    always_comb begin
        a_raw = '0;
        b_raw = '0;
        for (int i = 1; i < NREG; i++) begin
            if (AA == ADDR_W'(i)) a_raw = regs[i];
            if (BA == ADDR_W'(i)) b_raw = regs[i];
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Forwarding selects. wr_valid already excludes DA=0, so R0 never
    // forwards. Reset gates forwarding so both buses read zero while
    // RESET_N is held low, even if RW happens to be asserted.
    logic fwd_a;
    logic fwd_b;
    assign fwd_a = RESET_N && wr_valid && (DA == AA);
    assign fwd_b = RESET_N && wr_valid && (DA == BA);

    // Bus drive: forwarded write data when the read hits the pending write.
    always_comb begin
        ABus = fwd_a ? DData : a_raw;
        BBus = fwd_b ? DData : b_raw;
    end
`else
    // Bus drive: stored contents only; a same-cycle write shows after the edge.
    always_comb begin
        ABus = a_raw;
        BBus = b_raw;
    end
`endif

    // Status register: latches {V,C,N,Z} on FlagLd, independent of RW.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            Status <= 4'b0000;
        end else if (FlagLd) begin
            Status <= {V, C, N, Z};
        end
    end

endmodule

// File: tb/tb_datapath_register_file.sv
// Self-checking bench for datapath_register_file. Inputs change 1 time
// unit after each rising edge; outputs are sampled 1 time unit after the
// inputs settle, well away from the active edge. Expected values for
// forwarding cases follow the REGFILE_BYPASS_EN macro of the build.

module tb_datapath_register_file;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREG   = 1 << ADDR_W;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic [ADDR_W-1:0] aa, ba, da;
  logic              rw;
  logic [DATA_W-1:0] ddata;
  logic              flag_ld;
  logic              v, c, n, z;
  logic [DATA_W-1:0] abus, bbus;
  logic [3:0]        status;

  int n_checks = 0;
  int n_errors = 0;

  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] model [0:NREG-1];

  datapath_register_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .CLK    (clk),
    .RESET_N(rst_n),
    .AA     (aa),
    .BA     (ba),
    .DA     (da),
    .RW     (rw),
    .DData  (ddata),
    .FlagLd (flag_ld),
    .V      (v),
    .C      (c),
    .N      (n),
    .Z      (z),
    .ABus   (abus),
    .BBus   (bbus),
    .Status (status)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

  // checking task
  task automatic check(input string tag, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    rw = 1'b0; da = '0; ddata = '0; flag_ld = 1'b0;
    {v, c, n, z} = 4'b0000;
  endtask

  task automatic write_reg(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    rw = 1'b1; da = addr; ddata = data;
    tick();
    rw = 1'b0;
    if (addr != '0) model[addr] = data;
  endtask

  task automatic load_flags(input logic [3:0] f);
    {v, c, n, z} = f; flag_ld = 1'b1;
    tick();
    flag_ld = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NREG; i++) model[i] = '0;
    rst_n = 1'b0; aa = '0; ba = '0;
    idle_inputs();

    // reset state
    tick(); tick();
    aa = 5'd5; ba = 5'd31; settle();
    check("rst_abus", abus, '0);
    check("rst_bbus", bbus, '0);
    check("rst_status", {28'd0, status}, '0);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // async reset mid-cycle with preloaded R5 and flags
    write_reg(5'd5, 32'h12345678);
    load_flags(4'b1111);
    aa = 5'd5; settle();
    check("preload_r5", abus, 32'h12345678);
    check("preload_status", {28'd0, status}, 32'h0000000f);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_abus", abus, '0);
    check("async_rst_status", {28'd0, status}, '0);
    // write and flag load attempted during reset are overridden
    rw = 1'b1; da = 5'd5; ddata = 32'hCAFEF00D; flag_ld = 1'b1; {v, c, n, z} = 4'b1111;
    tick(); settle();
    check("rst_override_wr", abus, '0);
    check("rst_override_flag", {28'd0, status}, '0);
    idle_inputs();
    for (int i = 0; i < NREG; i++) model[i] = '0;
    @(negedge clk); rst_n = 1'b1;
    // first edge after release may write
    rw = 1'b1; da = 5'd9; ddata = 32'h00C0FFEE;
    tick(); rw = 1'b0; model[9] = 32'h00C0FFEE;
    aa = 5'd9; settle();
    check("first_edge_write", abus, 32'h00C0FFEE);

    // basic write / read
    write_reg(5'd3, 32'hFFFFFFFF);
    write_reg(5'd4, 32'h0FFFFFF0);
    aa = 5'd3; ba = 5'd4; settle();
    check("wr_rd_a3", abus, 32'hFFFFFFFF);
    check("wr_rd_b4", bbus, 32'h0FFFFFF0);
    aa = 5'd4; ba = 5'd4; settle();
    check("same_addr_a", abus, 32'h0FFFFFF0);
    check("same_addr_b", bbus, 32'h0FFFFFF0);

    // RW=0 changes nothing
    rw = 1'b0; da = 5'd3; ddata = 32'h11111111; aa = 5'd3;
    tick(); settle();
    check("rw0_hold", abus, 32'hFFFFFFFF);

    // R0 hardwired zero, including the pending-write case
    rw = 1'b1; da = 5'd0; ddata = 32'hDEADBEEF; aa = 5'd0; ba = 5'd3; settle();
    check("r0_pre_edge", abus, '0);
    tick(); rw = 1'b0; settle();
    check("r0_post_edge", abus, '0);
    check("r0_no_alias", bbus, 32'hFFFFFFFF);

    // same-cycle read/write of R7
    write_reg(5'd7, 32'h7FFFFFFA);
    rw = 1'b1; da = 5'd7; ddata = 32'h7FFFFFFB; aa = 5'd7; ba = 5'd6; settle();
    check("rdw_pre_a", abus, BYPASS ? 32'h7FFFFFFB : 32'h7FFFFFFA);
    check("rdw_pre_b_other", bbus, '0);
    tick(); rw = 1'b0; model[7] = 32'h7FFFFFFB; settle();
    check("rdw_post_a", abus, 32'h7FFFFFFB);

    // forwarding on B only, A reads a different register
    rw = 1'b1; da = 5'd6; ddata = 32'h66660006; aa = 5'd7; ba = 5'd6; settle();
    check("rdw_pre_b", bbus, BYPASS ? 32'h66660006 : 32'h00000000);
    check("rdw_pre_a_other", abus, 32'h7FFFFFFB);
    tick(); rw = 1'b0; model[6] = 32'h66660006; settle();
    check("rdw_post_b", bbus, 32'h66660006);

    // flags load and hold
    load_flags(4'b1010);
    settle();
    check("flags_load", {28'd0, status}, 32'h0000000a);
    {v, c, n, z} = 4'b0101; flag_ld = 1'b0;
    tick(); settle();
    check("flags_hold", {28'd0, status}, 32'h0000000a);
    {v, c, n, z} = 4'b1000; flag_ld = 1'b1;
    tick(); flag_ld = 1'b0; settle();
    check("flags_v_only", {28'd0, status}, 32'h00000008);

    // concurrent write and flag load
    rw = 1'b1; da = 5'd2; ddata = 32'h00000001; flag_ld = 1'b1; {v, c, n, z} = 4'b0001;
    tick(); idle_inputs(); model[2] = 32'h00000001;
    aa = 5'd2; settle();
    check("conc_r2", abus, 32'h00000001);
    check("conc_status", {28'd0, status}, 32'h00000001);

    // sweep: fill every register, then read back through both ports
    for (int i = 1; i < NREG; i++) write_reg(ADDR_W'(i), $urandom());
    for (int i = 0; i < NREG; i++) begin
      aa = ADDR_W'(i);
      ba = ADDR_W'((i * 7 + 3) % NREG);
      exp_q.push_back(model[i]);
      exp_q.push_back(model[(i * 7 + 3) % NREG]);
      settle();
      check($sformatf("sweep_a%0d", i), abus, exp_q.pop_front());
      check($sformatf("sweep_b%0d", (i * 7 + 3) % NREG), bbus, exp_q.pop_front());
    end

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
